// File: rtl/booth_result_bcd.sv
// Signed Booth product to sign / magnitude / packed BCD converter.
// Sequential double-dabble, one iteration per clock, valid/ready on both sides.
module booth_result_bcd #(
  parameter int unsigned WORD_LENGTH = 16,
  parameter int unsigned DIGITS      = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*WORD_LENGTH-1:0] Product,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     Sign,
  output logic [2*WORD_LENGTH-1:0] Magnitude,
  output logic [4*DIGITS-1:0]      Bcd,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned PW = 2 * WORD_LENGTH;
  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(PW) + 1;

  // 10^DIGITS must exceed the largest magnitude, 2^(PW-1).
  function automatic bit digits_sufficient();
    logic [511:0] pow;
    pow = 512'd1;
    for (int i = 0; i < int'(DIGITS); i++) pow = pow * 512'd10;
    return pow > (512'd1 << (PW - 1));
  endfunction

  localparam bit DigitsOk = digits_sufficient();

  if (!DigitsOk) begin : gen_digits_check
    $error("DIGITS too small to represent a 2*WORD_LENGTH-bit magnitude");
  end

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e          state_q, state_d;
  logic            sign_q;
  logic [PW-1:0]   mag_q;
  logic [PW-1:0]   shreg_q;
  logic [BW-1:0]   acc_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;

  logic [PW-1:0]   abs_product;
  logic [BW-1:0]   acc_adj;
  logic [BW-1:0]   acc_shift;
  logic [PW-1:0]   shreg_shift;
  logic            last_iter;

  // Unsigned result, so the most negative product maps cleanly to 2^(PW-1).
  always_comb begin
    abs_product = Product[PW-1] ? (~Product + PW'(1)) : Product;
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i+:4] >= 4'd5) acc_adj[4*i+:4] = acc_q[4*i+:4] + 4'd3;
    end
    acc_shift   = {acc_adj[BW-2:0], shreg_q[PW-1]};
    shreg_shift = {shreg_q[PW-2:0], 1'b0};
    last_iter   = (cnt_q == CW'(PW - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid)  state_d = StConvert;
      StConvert: if (last_iter) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_q  <= 1'b0;
      mag_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q  <= Product[PW-1];
            mag_q   <= abs_product;
            shreg_q <= abs_product;
            acc_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StConvert: begin
          acc_q   <= acc_shift;
          shreg_q <= shreg_shift;
          cnt_q   <= cnt_q + CW'(1);
          if (last_iter) bcd_q <= acc_shift;
        end
        default: ;
      endcase
    end
  end

  assign Sign      = sign_q;
  assign Magnitude = mag_q;
  assign Bcd       = bcd_q;

endmodule

// File: doc/booth_result_bcd.md
Name: booth_result_bcd

Overview:
- Downstream consumer of the Booth multiplier output.
- Accepts one signed 2*WORD_LENGTH-bit product per transaction.
- Converts it to sign plus unsigned magnitude plus packed BCD using sequential double-dabble, one iteration per clock.
- Feeds the display/readout stage through a valid/ready handshake on both sides.

Parameters:
- WORD_LENGTH, 16: multiplier operand width; product width is 2*WORD_LENGTH.
- DIGITS, 10: number of BCD digits produced. Must satisfy 10^DIGITS > 2^(2*WORD_LENGTH-1); elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- Product  input  2*WORD_LENGTH  signed two's-complement product from the multiplier.
- in_valid  input  1  Product is valid this cycle.
- in_ready  output  1  block can accept a product.
- Sign  output  1  1 = product negative.
- Magnitude  output  2*WORD_LENGTH  unsigned absolute value of product.
- Bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- out_valid  output  1  Sign/Magnitude/Bcd valid.
- out_ready  input  1  downstream accepts result.

Behaviour:
- One clock; reset is synchronous and active-low.
  - While reset is low at a clk edge: state <= IDLE; Sign, Magnitude, Bcd, iteration counter and shift registers <= 0; out_valid = 0; in_ready = 1 in the cycle following reset.
- FSM states: IDLE, CONVERT, DONE.
  - in_ready = (state == IDLE); out_valid = (state == DONE). Both are decoded from state registers; no combinational path from inputs to outputs.
- IDLE:
  - On an edge with in_valid = 1, capture: Sign <= Product[MSB].
  - Capture Magnitude and the shift register <= |Product|, computed as an unsigned 2*WORD_LENGTH-bit value. -2^(2W-1) maps to 2^(2W-1) with no overflow.
  - Clear the BCD accumulator and counter <= 0; go to CONVERT.
  - With in_valid = 0, remain in IDLE.
- CONVERT: each edge performs one double-dabble iteration.
  - Every BCD nibble >= 5 gets +3.
  - Then shift {BCD accumulator, shift register} left by 1; the shift-register MSB enters BCD bit 0.
  - counter <= counter + 1.
  - On the edge where counter == 2*WORD_LENGTH-1: perform the final iteration, load the Bcd output from the accumulator, go to DONE.
- DONE:
  - Outputs are held stable.
  - On an edge with out_ready = 1: go to IDLE.
  - With out_ready = 0: hold indefinitely. Sign, Magnitude and Bcd must not change.
- Latency: product accepted at edge T; out_valid is first high after edge T + 2*WORD_LENGTH (32 cycles at default).
  - Minimum issue interval is 2*WORD_LENGTH + 2 cycles with out_ready tied high.
- Sign, Magnitude and Bcd update only at capture (Sign, Magnitude) and at the CONVERT->DONE transition (Bcd). They hold their prior values during CONVERT.
- Zero product: Sign = 0, Magnitude = 0, Bcd = 0. Negative zero cannot occur.
- in_valid asserted during CONVERT/DONE is ignored: in_ready = 0, nothing is captured. Upstream must hold data until in_ready.
- Reset mid-CONVERT or mid-DONE: conversion is abandoned and all state returns to reset values on that edge. No partial result is ever flagged valid.
- Counter width: clog2(2*WORD_LENGTH)+1 bits; it must not wrap before the terminal compare.
- Unused high BCD digits read 0.

Test Plan:
- Product = -65520 (-32760 * 2, 32'hFFFF_0010), in_valid for 1 cycle, out_ready = 1 -> after exactly 32 cycles out_valid = 1 for 1 cycle, Sign = 1, Magnitude = 65520, Bcd = 40'h00_0006_5520; in_ready returns 1 the next cycle.
- Product = 1073741824 (-32768 * -32768) -> Sign = 0, Magnitude = 32'h4000_0000, Bcd = 40'h10_7374_1824.
- Product = -1073709056 (-32768 * 32767) -> Sign = 1, Magnitude = 1073709056, Bcd = 40'h10_7370_9056. Additionally, Product = 32'h8000_0000 -> Sign = 1, Bcd = 40'h21_4748_3648.
- Product = 0 -> Sign = 0, Magnitude = 0, Bcd = 0 after 32 cycles. Then, with out_ready = 0 for 10 cycles: out_valid stays 1, outputs stable, in_ready = 0, and a new in_valid pulse is ignored.
- Back-to-back: in_valid held high with Products 12345 then -7, out_ready = 1 -> results 40'h00_0001_2345 (Sign 0) then 40'h00_0000_0007 (Sign 1). The second capture occurs 34 cycles after the first.
- reset driven low for 1 cycle at iteration 10 of a conversion -> out_valid never asserts for that product; all outputs are 0 and in_ready = 1 after the reset edge; the next product converts correctly.
